// File: rtl/io_led_pkg.sv
// Shared definitions for the board activity LED driver: per-channel mode
// encoding and default timing for the 28 MHz system clock.
package io_led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'b00,
    LED_STRETCH = 2'b01,
    LED_LEVEL   = 2'b10,
    LED_BLINK   = 2'b11
  } led_mode_e;

  // About 1.8 ms of visible on-time and about 89 ms per blink half-period at 28 MHz
  localparam int DEFAULT_HOLD      = 50_000;
  localparam int DEFAULT_BLINK_DIV = 2_500_000;

endpackage

// File: rtl/activity_chan.sv
// One LED channel: retriggerable hold counter that stretches event strobes,
// followed by the mode mux producing the unregistered shaped value s.
module activity_chan
  import io_led_pkg::*;
#(
  parameter int HOLD   = DEFAULT_HOLD,
  parameter int HOLD_W = $clog2(HOLD + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       evt,
  input  logic [1:0] mode,
  input  logic       phase_next,
  output logic       active,
  output logic       s
);

  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] cnt_next;
  logic              hit;

  // The counter runs in every mode so a later mode change sees the remaining hold
  always_comb begin
    cnt_next = '0;
    if (evt) begin
      cnt_next = HOLD_W'(HOLD);
    end else if (cnt != '0) begin
      cnt_next = cnt - HOLD_W'(1);
    end
  end

  assign hit = (cnt_next != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      active <= hit;
    end
  end

  always_comb begin
    s = 1'b0;
    case (led_mode_e'(mode))
      LED_OFF:     s = 1'b0;
      LED_STRETCH: s = hit;
      LED_LEVEL:   s = evt;
      LED_BLINK:   s = hit & phase_next;
      default:     s = 1'b0;
    endcase
  end

endmodule

// File: rtl/activity_leds.sv
// Multi-channel activity LED driver: per-channel stretch/shape plus a shared
// blink generator and the optional active-low output stage.
module activity_leds
  import io_led_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int HOLD      = DEFAULT_HOLD,
  parameter int HOLD_W    = $clog2(HOLD + 1),
  parameter int BLINK_DIV = DEFAULT_BLINK_DIV,
  parameter bit INV       = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   evt,
  input  logic [2*NCH-1:0] mode,
  output logic [NCH-1:0]   active,
  output logic [NCH-1:0]   led
);

  // A divider of 1 still needs a one-bit prescaler that wraps every cycle
  localparam int PRE_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_next;
  logic             wrap;
  logic             phase;
  logic             phase_next;
  logic [NCH-1:0]   s;

  always_comb begin
    wrap       = (pre == PRE_W'(BLINK_DIV - 1));
    pre_next   = wrap ? '0 : pre + PRE_W'(1);
    phase_next = phase ^ wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre   <= '0;
      phase <= 1'b0;
    end else begin
      pre   <= pre_next;
      phase <= phase_next;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    activity_chan #(
      .HOLD   (HOLD),
      .HOLD_W (HOLD_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .evt        (evt[i]),
      .mode       (mode[2*i+1:2*i]),
      .phase_next (phase_next),
      .active     (active[i]),
      .s          (s[i])
    );
  end

  // Reset drives the pins to their dark level, whichever polarity the board uses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= {NCH{INV}};
    end else begin
      led <= s ^ {NCH{INV}};
    end
  end

endmodule

// File: tb/tb_activity_leds.sv
// Scoreboard bench for activity_leds: an active-high and an active-low
// instance share stimulus; expectations are queued per edge and checked by a monitor.
module tb_activity_leds;
  import io_led_pkg::*;

  localparam int NCH       = 4;
  localparam int HOLD      = 8;
  localparam int BLINK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] evt = 4'h0;
  logic [7:0] mode = 8'h00;
  logic [3:0] active;
  logic [3:0] led;
  logic [3:0] active_inv;
  logic [3:0] led_inv;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic [3:0] led;
    logic [3:0] act;
  } exp_t;

  exp_t sb[$];

  activity_leds #(
    .NCH       (NCH),
    .HOLD      (HOLD),
    .BLINK_DIV (BLINK_DIV),
    .INV       (1'b0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .evt    (evt),
    .mode   (mode),
    .active (active),
    .led    (led)
  );

  activity_leds #(
    .NCH       (NCH),
    .HOLD      (HOLD),
    .BLINK_DIV (BLINK_DIV),
    .INV       (1'b1)
  ) dut_inv (
    .clk    (clk),
    .rst    (rst),
    .evt    (evt),
    .mode   (mode),
    .active (active_inv),
    .led    (led_inv)
  );

  always #5 clk = ~clk;

  // Both instances are held to the same expectation; the active-low one sees inverted pins
  task automatic checkOutput(input string name, input logic [3:0] exp_led, input logic [3:0] exp_act);
    n_cmp += 4;
    if (led !== exp_led) begin
      n_fail++;
      $display("[TB] FAIL %s led: got %b want %b", name, led, exp_led);
    end
    if (active !== exp_act) begin
      n_fail++;
      $display("[TB] FAIL %s active: got %b want %b", name, active, exp_act);
    end
    if (led_inv !== ~exp_led) begin
      n_fail++;
      $display("[TB] FAIL %s led_inv: got %b want %b", name, led_inv, ~exp_led);
    end
    if (active_inv !== exp_act) begin
      n_fail++;
      $display("[TB] FAIL %s active_inv: got %b want %b", name, active_inv, exp_act);
    end
  endtask

  // Called at a falling edge: drive inputs for the next rising edge and queue its expected result
  task automatic applyStimulus(input string name, input logic [3:0] e, input logic [7:0] m,
                               input logic [3:0] exp_led, input logic [3:0] exp_act);
    exp_t x;
    evt = e;
    mode = m;
    x.name = name;
    x.led = exp_led;
    x.act = exp_act;
    sb.push_back(x);
    @(negedge clk);
  endtask

  task automatic doReset(input logic [3:0] e, input logic [7:0] m);
    @(negedge clk);
    rst = 1'b1;
    evt = e;
    mode = m;
    #1;
    checkOutput("reset_async", 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset_held", 4'h0, 4'h0);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin : monitor
    exp_t x;
    #2;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      checkOutput(x.name, x.led, x.act);
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [4:0] pat;
    logic       e1, e2, on, blk;
    int         wait_cyc;

    // Events held through reset show up one edge after release
    doReset(4'hF, {LED_OFF, LED_OFF, LED_OFF, LED_STRETCH});
    for (int k = 1; k <= 10; k++) begin
      applyStimulus($sformatf("release_e%0d", k), (k == 1) ? 4'hF : 4'h0, 8'h01,
                    (k <= 8) ? 4'b0001 : 4'b0000, (k <= 8) ? 4'hF : 4'h0);
    end

    // Stretch with a retrigger mid-hold on channel 0
    doReset(4'h0, 8'h01);
    for (int k = 1; k <= 25; k++) begin
      e1 = (k == 10) || (k == 15);
      on = (k >= 10) && (k <= 22);
      applyStimulus($sformatf("stretch_e%0d", k), {3'b000, e1}, 8'h01,
                    {3'b000, on}, {3'b000, on});
    end

    // Level mode on channel 1 mirrors evt one cycle later while active still stretches
    doReset(4'h0, 8'h08);
    pat = 5'b01101;
    for (int k = 1; k <= 13; k++) begin
      e1 = (k <= 5) ? pat[k-1] : 1'b0;
      on = (k <= 11);
      applyStimulus($sformatf("level_e%0d", k), {2'b00, e1, 1'b0}, 8'h08,
                    {2'b00, e1, 1'b0}, {2'b00, on, 1'b0});
    end

    // Blink on channel 2: phase flips every 4 edges, stops once the hold runs out
    doReset(4'h0, 8'h30);
    for (int k = 1; k <= 28; k++) begin
      e2  = (k <= 16);
      on  = (k <= 23);
      blk = on && (((k / 4) % 2) == 1);
      applyStimulus($sformatf("blink_e%0d", k), {1'b0, e2, 2'b00}, 8'h30,
                    {1'b0, blk, 2'b00}, {1'b0, on, 2'b00});
    end

    // Channel 3 hidden by OFF, then revealed by STRETCH with 5 counts left
    doReset(4'h0, 8'h00);
    for (int k = 1; k <= 11; k++) begin
      e1 = (k == 1);
      on = (k >= 5) && (k <= 8);
      applyStimulus($sformatf("off_switch_e%0d", k), {e1, 3'b000}, (k >= 5) ? 8'h40 : 8'h00,
                    {on, 3'b000}, {(k <= 8), 3'b000});
    end

    // Idle pins, then an asynchronous reset while every channel is mid-hold
    doReset(4'h0, 8'h55);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus($sformatf("all_e%0d", k), (k == 3) ? 4'hF : 4'h0, 8'h55,
                    (k >= 3) ? 4'hF : 4'h0, (k >= 3) ? 4'hF : 4'h0);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("reset_mid_hold", 4'h0, 4'h0);

    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/activity_leds.md
Name: activity_leds

Overview:
- Parametrised, multi-channel activity indicator driver for board LEDs.
- Each channel takes a single-clock event strobe from the floppy/harddisk FIFO read/write strobes or status bits.
- Each strobe is stretched to a visible, retriggerable on-time, then shaped by a per-channel runtime mode (off / stretch / level / blink).
- Sits in the io block between the FIFO/control logic and the top-level LED pins; replaces fixed 2-cycle OR-stretching and fixed channel packing.

Parameters:
- NCH, 8, number of LED channels (>=1).
- HOLD, 50000, on-time in clk cycles after the last event (>=1).
- HOLD_W, $clog2(HOLD+1), width of the per-channel hold counter (derived; do not override).
- BLINK_DIV, 2500000, clk cycles per blink half-period (>=1).
- INV, 0, 1 = active-low LED pins (output inverted after shaping).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- evt  in  NCH  per-channel event strobe, synchronous to clk, level or pulse.
- mode  in  2*NCH  per-channel mode, channel i at [2i+1:2i]; 00 OFF, 01 STRETCH, 10 LEVEL, 11 BLINK.
- active  out  NCH  per-channel stretched activity (cnt!=0), registered, never inverted.
- led  out  NCH  LED drive after mode shaping and INV.

Behaviour:
- Reset (asynchronous):
  - all hold counters 0, blink prescaler 0, blink phase 0;
  - active = 0;
  - led = {NCH{INV}}, i.e. LEDs dark.
- Hold counter per channel, updated every edge regardless of mode:
  - evt[i]=1: cnt_next = HOLD (retrigger, reloads even mid-hold);
  - else cnt!=0: cnt_next = cnt-1;
  - else cnt_next = 0.
  - Counter never wraps below 0.
- active[i] <= (cnt_next != 0):
  - a 1-cycle evt sampled at edge k gives active high after edge k, for exactly HOLD cycles, low after edge k+HOLD;
  - continuous evt keeps active high; the HOLD cycles count from the last evt cycle.
- Blink generator (global, shared by all channels):
  - prescaler counts 0..BLINK_DIV-1, wraps to 0;
  - on wrap, phase toggles;
  - phase_next is the value after this edge.
- Shaped value s[i], registered; led[i] <= s[i] ^ INV:
  - OFF: s = 0.
  - STRETCH: s = (cnt_next != 0).
  - LEVEL: s = evt[i] (1-cycle latency, no stretch).
  - BLINK: s = (cnt_next != 0) & phase_next; inactive channel in BLINK stays dark.
- Latency: led and active are registered; 1 cycle from evt to output in every mode.
- Mode is combinational per cycle and may change at any time:
  - output follows the new mode at the next edge;
  - hold counter is unaffected by mode, so switching OFF->STRETCH mid-hold shows the remaining hold.
- Simultaneous evt on several channels are independent; no arbitration.
- Reset mid-hold or mid-blink clears everything immediately; first edge after deassertion behaves as from idle.
- No X propagation: evt and mode must be driven; unused channels tie evt=0, mode=00.

Decomposition:
- Package io_led_pkg holds:
  - mode constants LED_OFF=2'b00, LED_STRETCH=2'b01, LED_LEVEL=2'b10, LED_BLINK=2'b11;
  - default HOLD/BLINK_DIV values for the 28 MHz system clock.
- Sub-module activity_chan: one channel's hold counter plus mode mux, taking evt, mode and phase_next, producing active and s. Instantiated NCH times in a generate loop.
- The blink prescaler and the INV stage stay in the top module.

Test Plan (NCH=4, HOLD=8, BLINK_DIV=4, INV=0 unless stated):
- Reset with evt=4'hF held → led=0, active=0 during rst; channel 0 in STRETCH shows active[0]=1 one edge after rst deasserts.
- Channel 0 STRETCH, 1-cycle evt at edge 10 → led[0]=1 after edges 10..17, 0 after edge 18; retrigger at edge 15 extends to 0 after edge 23.
- Channel 1 LEVEL, evt pattern 1,0,1,1,0 → led[1] shows the same pattern delayed one cycle, with no stretch.
- Channel 2 BLINK, evt held high → led[2] toggles every 4 cycles (4 on, 4 off), aligned to phase; after evt drops, blinking stops within 8 cycles and led[2]=0.
- Channel 3 OFF → led[3]=0 while active[3]=1; switch mode to STRETCH mid-hold with cnt=5 → led[3]=1 for the remaining 4 cycles.
- INV=1 → led=4'hF in reset and when idle; rst asserted mid-hold on all channels → led=4'hF and active=0 immediately (asynchronous).
